// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port seen by dmem_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface dmem_arbiter_if #(
    parameter int W = 8,
    parameter int A = 8
);
    logic         req0_valid;
    logic         req0_write;
    logic [A-1:0] req0_addr;
    logic [W-1:0] req0_wdata;
    logic         req0_lock;
    logic         req0_ready;
    logic         rsp0_valid;
    logic [W-1:0] rsp0_data;

    logic         req1_valid;
    logic         req1_write;
    logic [A-1:0] req1_addr;
    logic [W-1:0] req1_wdata;
    logic         req1_lock;
    logic         req1_ready;
    logic         rsp1_valid;
    logic [W-1:0] rsp1_data;

    logic         mem_we;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata, req0_lock,
        output req0_ready, rsp0_valid, rsp0_data,
        input  req1_valid, req1_write, req1_addr, req1_wdata, req1_lock,
        output req1_ready, rsp1_valid, rsp1_data,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata, req0_lock,
        input  req0_ready, rsp0_valid, rsp0_data,
        output req1_valid, req1_write, req1_addr, req1_wdata, req1_lock,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port 256x8 data memory,
// with a bounded burst lock and one-cycle registered load responses.
module dmem_arbiter #(
    parameter int W         = 8,
    parameter int A         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;        // 1: port 1 was granted most recently
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_inc;
    logic          grant0, grant1;

    logic          rsp0_valid_q, rsp1_valid_q;
    logic [W-1:0]  rsp0_data_q, rsp1_data_q;

    assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);

    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant0  = 1'b0;
        grant1  = 1'b0;

        if (!Reset) begin
            state_d = state_q;
        end else if (state_q == ST_LOCK0 && bus.req0_valid) begin
            grant0  = 1'b1;
            last_d  = 1'b0;
            cnt_d   = cnt_inc[CW-1:0];
            state_d = (bus.req0_lock && cnt_inc < (CW+1)'(MAX_BURST)) ? ST_LOCK0 : ST_ARB;
        end else if (state_q == ST_LOCK1 && bus.req1_valid) begin
            grant1  = 1'b1;
            last_d  = 1'b1;
            cnt_d   = cnt_inc[CW-1:0];
            state_d = (bus.req1_lock && cnt_inc < (CW+1)'(MAX_BURST)) ? ST_LOCK1 : ST_ARB;
        end else begin
            // Plain arbitration, also taken in the same cycle an owner lets go.
            state_d = ST_ARB;
            cnt_d   = '0;
            if (bus.req0_valid && (!bus.req1_valid || last_q)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end

            if (grant0) begin
                last_d = 1'b0;
                if (bus.req0_lock && MAX_BURST > 1) begin
                    state_d = ST_LOCK0;
                    cnt_d   = CW'(1);
                end
            end else if (grant1) begin
                last_d = 1'b1;
                if (bus.req1_lock && MAX_BURST > 1) begin
                    state_d = ST_LOCK1;
                    cnt_d   = CW'(1);
                end
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.mem_we     = (grant0 && bus.req0_write) || (grant1 && bus.req1_write);
    assign bus.mem_addr   = grant0 ? bus.req0_addr  : (grant1 ? bus.req1_addr  : '0);
    assign bus.mem_wdata  = grant0 ? bus.req0_wdata : (grant1 ? bus.req1_wdata : '0);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_ARB;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the response data registers are reset too, since their value is
    // architecturally visible (held between loads) and must read 0 after reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            rsp0_valid_q <= grant0 && !bus.req0_write;
            rsp1_valid_q <= grant1 && !bus.req1_write;
            if (grant0 && !bus.req0_write) rsp0_data_q <= bus.mem_rdata;
            if (grant1 && !bus.req1_write) rsp1_data_q <= bus.mem_rdata;
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp1_data  = rsp1_data_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, compared against a grant/burst/memory reference model.
module tb_dmem_arbiter;
    localparam int MAX_BURST = 4;

    logic Clk = 1'b0;
    logic Reset;

    dmem_arbiter_if #(.W(8), .A(8)) bus ();

    dmem_arbiter #(.W(8), .A(8), .MAX_BURST(MAX_BURST)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Memory environment: combinational read, write at posedge.
    logic [7:0] tb_mem [256];
    assign bus.mem_rdata = tb_mem[bus.mem_addr];
    always @(posedge Clk) if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;

    // Reference model
    logic [7:0] model_mem [256];
    int         m_owner, m_run, m_last;
    logic       exp_rv [2];
    logic [7:0] exp_rd [2];

    // Requests being driven
    logic       tv [2], tw [2], tl [2];
    logic [7:0] ta [2], td [2];

    int   total, bad, last_g;
    logic obs_r0, obs_r1;
    int   pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic w,
                           input logic [7:0] a, input logic [7:0] d, input logic l);
        tv[p] = v; tw[p] = w; ta[p] = a; td[p] = d; tl[p] = l;
    endtask

    task automatic idle();
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic apply();
        bus.req0_valid = tv[0]; bus.req0_write = tw[0]; bus.req0_addr = ta[0];
        bus.req0_wdata = td[0]; bus.req0_lock  = tl[0];
        bus.req1_valid = tv[1]; bus.req1_write = tw[1]; bus.req1_addr = ta[1];
        bus.req1_wdata = td[1]; bus.req1_lock  = tl[1];
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_run = 0;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    endtask

    // A live burst owner keeps the memory; otherwise the port that was not
    // served last wins a tie.
    function automatic int model_grant();
        if (m_owner >= 0 && tv[m_owner]) return m_owner;
        if (tv[0] && tv[1]) return 1 - m_last;
        if (tv[0]) return 0;
        if (tv[1]) return 1;
        return -1;
    endfunction

    task automatic model_update(input int g);
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        if (g >= 0) begin
            if (tw[g]) model_mem[ta[g]] = td[g];
            else begin
                exp_rv[g] = 1'b1;
                exp_rd[g] = model_mem[ta[g]];
            end
            m_run   = (g == m_owner) ? m_run + 1 : 1;
            m_last  = g;
            m_owner = (tl[g] && m_run < MAX_BURST) ? g : -1;
        end else begin
            m_owner = -1;
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic do_cycle();
        int g;
        apply();
        @(negedge Clk);
        g = model_grant();
        obs_r0 = bus.req0_ready;
        obs_r1 = bus.req1_ready;
        chk("ready0", 32'(bus.req0_ready), 32'(g == 0));
        chk("ready1", 32'(bus.req1_ready), 32'(g == 1));
        chk("mem_we", 32'(bus.mem_we), 32'((g >= 0) ? tw[g] : 1'b0));
        chk("mem_addr", 32'(bus.mem_addr), 32'((g >= 0) ? ta[g] : 8'h00));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'((g >= 0) ? td[g] : 8'h00));
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(exp_rv[0]));
        chk("rsp0_data", 32'(bus.rsp0_data), 32'(exp_rd[0]));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(exp_rv[1]));
        chk("rsp1_data", 32'(bus.rsp1_data), 32'(exp_rd[1]));
        model_update(g);
        last_g = g;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [7:0] r;
        total = 0; bad = 0; last_g = -1;
        for (int i = 0; i < 256; i++) begin
            r = 8'($urandom);
            if (i == 'h90 && r == 8'h5A) r = 8'h00;
            tb_mem[i] <= r;
            model_mem[i] = r;
        end
        idle();
        apply();
        model_reset();
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;

        // Reset release, nothing requested
        do_cycle();

        // Both ports load on the same cycle: port 0 first, then port 1
        set_req(0, 1'b1, 1'b0, 8'h34, 8'h00, 1'b0);
        set_req(1, 1'b1, 1'b0, 8'h35, 8'h00, 1'b0);
        do_cycle();
        chk("t2_first_p0", 32'(obs_r0), 32'(1));
        tv[0] = 1'b0;
        do_cycle();
        chk("t2_then_p1", 32'(obs_r1), 32'(1));
        idle();
        do_cycle();

        // Port 1 stores, port 0 reads it back on the next cycle
        set_req(1, 1'b1, 1'b1, 8'h80, 8'hA5, 1'b0);
        do_cycle();
        idle();
        set_req(0, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0);
        do_cycle();
        chk("t3_rsp_valid", 32'(bus.rsp0_valid), 32'(1));
        chk("t3_rsp_data", 32'(bus.rsp0_data), 32'(8'hA5));

        // Port 1 locks continuously against a waiting port 0
        for (int i = 0; i < 10; i++) begin
            set_req(0, 1'b1, 1'b0, 8'h41, 8'h00, 1'b0);
            set_req(1, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1);
            do_cycle();
            chk("t4_burst_pattern", 32'(obs_r1), 32'(pat[i]));
        end

        // Owner drops valid inside a lock: port 0 served in the same cycle
        idle();
        set_req(1, 1'b1, 1'b0, 8'h42, 8'h00, 1'b1);
        do_cycle();
        idle();
        set_req(0, 1'b1, 1'b0, 8'h43, 8'h00, 1'b0);
        do_cycle();
        chk("t5_handover", 32'(obs_r0), 32'(1));
        set_req(1, 1'b1, 1'b0, 8'h46, 8'h00, 1'b0);
        do_cycle();

        // Reset asserted between edges during a lock, port 0 store waiting
        idle();
        set_req(1, 1'b1, 1'b0, 8'h44, 8'h00, 1'b1);
        do_cycle();
        set_req(1, 1'b1, 1'b0, 8'h45, 8'h00, 1'b1);
        set_req(0, 1'b1, 1'b1, 8'h90, 8'h5A, 1'b0);
        apply();
        #2;
        chk("t6_lock_ready1", 32'(bus.req1_ready), 32'(1));
        chk("t6_wait_ready0", 32'(bus.req0_ready), 32'(0));
        chk("t6_prev_rsp1", 32'(bus.rsp1_valid), 32'(1));
        #1;
        Reset = 1'b0;
        #1;
        chk("t6_rst_ready0", 32'(bus.req0_ready), 32'(0));
        chk("t6_rst_ready1", 32'(bus.req1_ready), 32'(0));
        chk("t6_rst_we", 32'(bus.mem_we), 32'(0));
        chk("t6_rst_addr", 32'(bus.mem_addr), 32'(0));
        chk("t6_rst_wdata", 32'(bus.mem_wdata), 32'(0));
        chk("t6_rst_rsp0", 32'(bus.rsp0_valid), 32'(0));
        chk("t6_rst_rsp1", 32'(bus.rsp1_valid), 32'(0));
        chk("t6_rst_rsp1_data", 32'(bus.rsp1_data), 32'(0));
        model_reset();
        @(posedge Clk);
        #1;
        chk("t6_mem_kept", 32'(tb_mem[8'h90]), 32'(model_mem[8'h90]));
        Reset = 1'b1;
        do_cycle();
        chk("t6_p0_first", 32'(obs_r0), 32'(1));
        tv[0] = 1'b0;
        do_cycle();

        // Random traffic; a request not yet granted is held stable
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(tv[p] && last_g != p)) begin
                    set_req(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                            8'(8'h60 + $urandom_range(0, 15)), 8'($urandom),
                            1'($urandom_range(0, 1)));
                end
            end
            do_cycle();
        end
        idle();
        do_cycle();
        do_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
